// File: rtl/axis_demux_1_2.sv
// axis_demux_1_2 : AXI-Stream 1:2 frame demultiplexer.
// Each frame (delimited by Tlast) is steered to lane 0 or lane 1. The lane
// is chosen by sel on the frame's first accepted beat. A one-entry output
// register decouples the handshake. A per-lane counter records the frames
// completed on that lane.
// Build option: define AXIS_DEMUX_CNT_SAT_EN to make the frame counters
// saturate at 2^CNT_W-1. When it is undefined they wrap modulo 2^CNT_W.
module axis_demux_1_2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] s_Tdata,
  input  logic              s_Tvalid,
  input  logic              s_Tlast,
  output logic              s_Tready,
  output logic [DATA_W-1:0] m0_Tdata,
  output logic              m0_Tvalid,
  output logic              m0_Tlast,
  input  logic              m0_Tready,
  output logic [DATA_W-1:0] m1_Tdata,
  output logic              m1_Tvalid,
  output logic              m1_Tlast,
  input  logic              m1_Tready,
  output logic [CNT_W-1:0]  frame_cnt0,
  output logic [CNT_W-1:0]  frame_cnt1,
  output logic              busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              route_q, route_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              dest_q, dest_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic dest_ready;
  logic accept;
  logic deliver;
  logic beat_dest;

  // Next counter value. It either wraps or sticks at all-ones, depending on the build.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c);
`ifdef AXIS_DEMUX_CNT_SAT_EN
    return (&c) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  // The slave may push whenever the register is empty or its beat leaves this cycle.
  assign dest_ready = dest_q ? m1_Tready : m0_Tready;
  assign s_Tready   = !valid_q || dest_ready;
  assign accept     = s_Tvalid && s_Tready;
  assign deliver    = valid_q && dest_ready;
  // A frame's first beat follows sel live. Later beats follow the latched route.
  assign beat_dest  = (state_q == IDLE) ? sel : route_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignment, so every
    // flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // FSM next state: open a frame on a non-last first beat, close it on Tlast.
  always_comb begin
    // NOTE: defaults first so that no path leaves a signal unassigned;
    // otherwise a latch would be inferred.
    state_d = state_q;
    route_d = route_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          route_d = sel;
          if (!s_Tlast) state_d = ROUTE;
        end
      end
      ROUTE: begin
        if (accept && s_Tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy marks an open multi-beat frame.
  always_comb begin
    busy = (state_q == ROUTE);
  end

  // Output register and frame counters.
  always_ff @(posedge clk) begin
    // NOTE: the data/last fields are reset as well as valid. The lanes must
    // read zero after reset, so these cannot be left as don't-care flops.
    if (reset) begin
      data_q  <= '0;
      last_q  <= 1'b0;
      dest_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      data_q  <= data_d;
      last_q  <= last_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Register load/drain. An accept overrides a drain in the same cycle.
  // Counters step when a Tlast beat leaves.
  always_comb begin
    data_d  = data_q;
    last_d  = last_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      data_d  = s_Tdata;
      last_d  = s_Tlast;
      dest_d  = beat_dest;
      valid_d = 1'b1;
    end else if (deliver) begin
      valid_d = 1'b0;
    end
    if (deliver && last_q) begin
      if (dest_q) cnt1_d = cnt_next(cnt1_q);
      else        cnt0_d = cnt_next(cnt0_q);
    end
  end

  // Both lanes see the held beat. Only the destination lane asserts valid.
  assign m0_Tdata   = data_q;
  assign m1_Tdata   = data_q;
  assign m0_Tlast   = last_q;
  assign m1_Tlast   = last_q;
  assign m0_Tvalid  = valid_q && !dest_q;
  assign m1_Tvalid  = valid_q && dest_q;
  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_demux_1_2.sv
// tb_axis_demux_1_2 : self-checking bench for axis_demux_1_2.
// The reference model keeps one queue of expected beats per lane. It
// follows the frame-level routing rule and counts delivered frames per
// lane. Directed scenarios run first, then a long randomized run.
module tb_axis_demux_1_2;

  localparam int DATA_W  = 8;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              sel;
  logic [DATA_W-1:0] s_Tdata;
  logic              s_Tvalid;
  logic              s_Tlast;
  logic              s_Tready;
  logic [DATA_W-1:0] m0_Tdata, m1_Tdata;
  logic              m0_Tvalid, m1_Tvalid;
  logic              m0_Tlast, m1_Tlast;
  logic              m0_Tready, m1_Tready;
  logic [CNT_W-1:0]  frame_cnt0, frame_cnt1;
  logic              busy;

  int n_vec  = 0;
  int n_fail = 0;

  axis_demux_1_2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .s_Tdata    (s_Tdata),
    .s_Tvalid   (s_Tvalid),
    .s_Tlast    (s_Tlast),
    .s_Tready   (s_Tready),
    .m0_Tdata   (m0_Tdata),
    .m0_Tvalid  (m0_Tvalid),
    .m0_Tlast   (m0_Tlast),
    .m0_Tready  (m0_Tready),
    .m1_Tdata   (m1_Tdata),
    .m1_Tvalid  (m1_Tvalid),
    .m1_Tlast   (m1_Tlast),
    .m1_Tready  (m1_Tready),
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0] q0[$];   // {last, data} of beats expected on lane 0
  logic [8:0] q1[$];
  int         m_cnt0, m_cnt1;
  bit         m_in_frame;
  bit         m_route;

  function automatic int bump(input int c);
`ifdef AXIS_DEMUX_CNT_SAT_EN
    return (c == CNT_MAX) ? c : c + 1;
`else
    return (c + 1) % (CNT_MAX + 1);
`endif
  endfunction

  // Outputs are checked at the falling edge. Then the model applies what
  // the coming rising edge will do.
  always @(negedge clk) begin
    logic [8:0] b;
    bit         d;
    bit         exp_rdy;
    if (reset) begin
      q0.delete();
      q1.delete();
      m_cnt0     = 0;
      m_cnt1     = 0;
      m_in_frame = 0;
      m_route    = 0;
    end else begin
      check("outstanding", q0.size() + q1.size(), int'(m0_Tvalid) + int'(m1_Tvalid));
      if (m0_Tvalid) begin
        if (q0.size() == 0) check("m0_spurious", 1, 0);
        else                check("m0_beat", {m0_Tlast, m0_Tdata}, q0[0]);
      end
      if (m1_Tvalid) begin
        if (q1.size() == 0) check("m1_spurious", 1, 0);
        else                check("m1_beat", {m1_Tlast, m1_Tdata}, q1[0]);
      end
      exp_rdy = !(m0_Tvalid || m1_Tvalid) || (m0_Tvalid && m0_Tready) || (m1_Tvalid && m1_Tready);
      check("s_Tready", s_Tready, exp_rdy);
      check("busy", busy, m_in_frame);
      check("frame_cnt0", frame_cnt0, m_cnt0);
      check("frame_cnt1", frame_cnt1, m_cnt1);

      if (m0_Tvalid && m0_Tready && q0.size() > 0) begin
        b = q0.pop_front();
        if (b[8]) m_cnt0 = bump(m_cnt0);
      end
      if (m1_Tvalid && m1_Tready && q1.size() > 0) begin
        b = q1.pop_front();
        if (b[8]) m_cnt1 = bump(m_cnt1);
      end
      if (s_Tvalid && s_Tready) begin
        if (!m_in_frame) m_route = sel;
        d = m_route;
        if (d) q1.push_back({s_Tlast, s_Tdata});
        else   q0.push_back({s_Tlast, s_Tdata});
        m_in_frame = !s_Tlast;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // All drives happen 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_Tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_s_Tready"},  s_Tready, 1);
    check({tag, "_m0_Tvalid"}, m0_Tvalid, 0);
    check({tag, "_m1_Tvalid"}, m1_Tvalid, 0);
    check({tag, "_m0_Tdata"},  m0_Tdata, 0);
    check({tag, "_m1_Tdata"},  m1_Tdata, 0);
    check({tag, "_m0_Tlast"},  m0_Tlast, 0);
    check({tag, "_m1_Tlast"},  m1_Tlast, 0);
    check({tag, "_cnt0"},      frame_cnt0, 0);
    check({tag, "_cnt1"},      frame_cnt1, 0);
    check({tag, "_busy"},      busy, 0);
    step();
  endtask

  task automatic do_reset();
    s_Tvalid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
  endtask

  // Hold the beat until it is accepted. The stall count goes in waits.
  task automatic send_beat(input logic [7:0] d, input logic l, input logic s, output int waits);
    bit done;
    s_Tvalid = 1'b1;
    s_Tdata  = d;
    s_Tlast  = l;
    sel      = s;
    waits    = 0;
    done     = 0;
    while (!done) begin
      @(negedge clk);
      if (s_Tready) begin
        done = 1;
      end else begin
        waits++;
        if (waits > 50) begin
          check("accept_timeout", 0, 1);
          done = 1;
        end
      end
      step();
    end
  endtask

  task automatic check_counts(input string tag, input int e0, input int e1);
    @(negedge clk);
    check({tag, "_cnt0"}, frame_cnt0, e0);
    check({tag, "_cnt1"}, frame_cnt1, e1);
    step();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          w;
    logic [7:0]  bytes4 [4];
    bit          acc;
    int          exp_lim;

    reset     = 1'b1;
    sel       = 1'b0;
    s_Tdata   = '0;
    s_Tvalid  = 1'b0;
    s_Tlast   = 1'b0;
    m0_Tready = 1'b1;
    m1_Tready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_reset_outputs("rst");

    // Lane-0 frame at full throughput.
    bytes4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      send_beat(bytes4[i], i == 3, 1'b0, w);
      check("l0_stall", w, 0);
    end
    idle(3);
    check_counts("l0", 1, 0);

    // A sel toggle mid-frame must not move the frame off lane 1.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_beat(8'h50 + 8'(i), i == 4, (i % 2) == 0, w);
      check("tog_stall", w, 0);
    end
    idle(3);
    check_counts("tog", 0, 1);

    // Backpressure on lane 1 for three cycles mid-frame.
    do_reset();
    send_beat(8'hA0, 1'b0, 1'b1, w);
    send_beat(8'hA1, 1'b0, 1'b1, w);
    m1_Tready = 1'b0;
    s_Tvalid  = 1'b1;
    s_Tdata   = 8'hA2;
    s_Tlast   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_s_Tready", s_Tready, 0);
      check("bp_m1_Tvalid", m1_Tvalid, 1);
      check("bp_m1_Tdata", m1_Tdata, 8'hA1);
      check("bp_m1_Tlast", m1_Tlast, 0);
      step();
    end
    m1_Tready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      send_beat(8'hA0 + 8'(i), i == 5, 1'b1, w);
      check("bp_resume_stall", w, 0);
    end
    idle(3);
    check_counts("bp", 0, 1);

    // Back-to-back single-beat frames on alternating lanes.
    do_reset();
    send_beat(8'hC0, 1'b1, 1'b0, w);
    send_beat(8'hC1, 1'b1, 1'b1, w);
    send_beat(8'hC2, 1'b1, 1'b0, w);
    idle(3);
    check_counts("single", 2, 1);

    // Reset after two beats of a four-beat frame.
    do_reset();
    send_beat(8'hD0, 1'b0, 1'b0, w);
    send_beat(8'hD1, 1'b0, 1'b0, w);
    do_reset();
    check_reset_outputs("midrst");
    send_beat(8'hD2, 1'b1, 1'b1, w);
    idle(3);
    check_counts("midrst", 0, 1);

    // Counter limit: 33 single-beat frames on lane 0.
    do_reset();
    for (int i = 0; i < 33; i++) send_beat(8'(i), 1'b1, 1'b0, w);
    idle(3);
`ifdef AXIS_DEMUX_CNT_SAT_EN
    exp_lim = 31;
`else
    exp_lim = 1;
`endif
    check_counts("limit", exp_lim, 0);

    // Randomized traffic. An unaccepted beat is held until it is taken.
    do_reset();
    acc = 1;
    for (int i = 0; i < 4000; i++) begin
      if (!s_Tvalid || acc) begin
        s_Tvalid = ($urandom_range(0, 9) < 7);
        s_Tdata  = 8'($urandom);
        s_Tlast  = ($urandom_range(0, 3) == 0);
      end
      sel       = 1'($urandom);
      m0_Tready = ($urandom_range(0, 3) != 0);
      m1_Tready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      acc = (s_Tvalid && s_Tready) || reset;
      step();
    end
    reset     = 1'b0;
    m0_Tready = 1'b1;
    m1_Tready = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
